// File: rtl/cool_heat_pkg.sv
// Shared definitions for the cool/heat thermostat and fan driver.
//   - FSM state encodings (IDLE/HEAT/COOL)
//   - Fan band duty constants and temperature band edges
//   - fan_band(): maps (state, temperature) to the fan duty and level
package cool_heat_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HEAT = 2'd1;
    localparam state_t ST_COOL = 2'd2;

    localparam logic [7:0] DUTY_OFF  = 8'd0;
    localparam logic [7:0] DUTY_LOW  = 8'd100;
    localparam logic [7:0] DUTY_MID  = 8'd180;
    localparam logic [7:0] DUTY_HIGH = 8'd255;

    // Lower edges of the mid and high cooling bands.
    localparam logic [7:0] BAND_MID_EDGE  = 8'd40;
    localparam logic [7:0] BAND_HIGH_EDGE = 8'd45;

    typedef struct packed {
        logic [7:0] duty;
        logic [1:0] level;
    } fan_band_t;

    function automatic fan_band_t fan_band(input state_t state, input logic [7:0] temp);
        fan_band_t band;
        band.duty  = DUTY_OFF;
        band.level = 2'd0;
        case (state)
            ST_HEAT: begin
                band.duty  = DUTY_LOW;
                band.level = 2'd1;
            end
            ST_COOL: begin
                if (temp < BAND_MID_EDGE) begin
                    band.duty  = DUTY_LOW;
                    band.level = 2'd1;
                end else if (temp < BAND_HIGH_EDGE) begin
                    band.duty  = DUTY_MID;
                    band.level = 2'd2;
                end else begin
                    band.duty  = DUTY_HIGH;
                    band.level = 2'd3;
                end
            end
            default: begin
                band.duty  = DUTY_OFF;
                band.level = 2'd0;
            end
        endcase
        return band;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Fan PWM generator.
// Latches the requested duty/level only on the cycle cnt==8'hFF so that a new duty starts
// cleanly at the next 256-cycle period, then drives a registered compare against cnt.
// Ports:
//   clk         in   system clock
//   arst_n      in   asynchronous active-low reset
//   cnt         in   free-running 8-bit PWM timebase
//   duty_next   in   requested duty for the next period
//   level_next  in   requested fan level for the next period
//   fan_pwm     out  registered PWM drive (cnt < duty_q, 1 clk latency)
//   fan_level   out  fan level in effect for the current period
module fan_pwm_gen (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] cnt,
    input  logic [7:0] duty_next,
    input  logic [1:0] level_next,
    output logic       fan_pwm,
    output logic [1:0] fan_level
);

    logic [7:0] duty_q, duty_d;
    logic [1:0] level_q, level_d;
    logic       pwm_q, pwm_d;

    always_comb begin
        duty_d  = duty_q;
        level_d = level_q;
        if (cnt == 8'hFF) begin
            duty_d  = duty_next;
            level_d = level_next;
        end
        // Uses the duty in effect now; at cnt==FF this is always 0, so the
        // period boundary never produces a runt pulse.
        pwm_d = (cnt < duty_q);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            duty_q  <= 8'd0;
            level_q <= 2'd0;
            pwm_q   <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign fan_pwm   = pwm_q;
    assign fan_level = level_q;

endmodule

// File: rtl/cool_heat_fan_ctrl.sv
// Thermostat and fan driver for the cool/heat subsystem.
// Samples temperature on temp_valid, runs an IDLE/HEAT/COOL hysteresis FSM with a minimum
// dwell per state, drives registered heater/cooler enables and a banded fan PWM.
// Ports:
//   clk          in   system clock
//   arst_n       in   asynchronous active-low reset
//   temperature  in   unsigned temperature, degrees C
//   temp_valid   in   strobe: temperature valid this cycle
//   cnt          in   free-running 8-bit PWM timebase
//   heater_on    out  heater enable
//   cooler_on    out  cooler enable
//   fan_pwm      out  fan PWM drive
//   fan_level    out  active fan band (0 off, 1 low, 2 mid, 3 high)
module cool_heat_fan_ctrl
    import cool_heat_pkg::*;
#(
    parameter logic [7:0]  HEAT_ON  = 8'd15,
    parameter logic [7:0]  HEAT_OFF = 8'd30,
    parameter logic [7:0]  COOL_ON  = 8'd35,
    parameter logic [7:0]  COOL_OFF = 8'd25,
    parameter logic [15:0] DWELL    = 16'd64
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] temperature,
    input  logic       temp_valid,
    input  logic [7:0] cnt,
    output logic       heater_on,
    output logic       cooler_on,
    output logic       fan_pwm,
    output logic [1:0] fan_level
);

    state_t      state_q, state_d;
    logic [7:0]  temp_q, temp_d;
    logic [15:0] dwell_q, dwell_d;
    logic        heater_q, cooler_q;
    fan_band_t   band;

    always_comb begin
        temp_d = temp_valid ? temperature : temp_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (temp_q < HEAT_ON) begin
                    state_d = ST_HEAT;
                end else if (temp_q > COOL_ON) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: if (temp_q >= HEAT_OFF) state_d = ST_IDLE;
            ST_COOL: if (temp_q < COOL_OFF)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Any legal encoding must serve its full dwell before leaving.
        if (dwell_q != DWELL && state_q != 2'd3) begin
            state_d = state_q;
        end

        if (state_d != state_q) begin
            dwell_d = 16'd0;
        end else if (dwell_q != DWELL) begin
            dwell_d = dwell_q + 16'd1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            temp_q   <= 8'd0;
            dwell_q  <= 16'd0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            dwell_q  <= dwell_d;
            heater_q <= (state_q == ST_HEAT);
            cooler_q <= (state_q == ST_COOL);
        end
    end

    assign band = fan_band(state_q, temp_q);

    fan_pwm_gen u_fan_pwm_gen (
        .clk        (clk),
        .arst_n     (arst_n),
        .cnt        (cnt),
        .duty_next  (band.duty),
        .level_next (band.level),
        .fan_pwm    (fan_pwm),
        .fan_level  (fan_level)
    );

    assign heater_on = heater_q;
    assign cooler_on = cooler_q;

endmodule

// File: tb/tb_cool_heat_fan_ctrl.sv
// Directed bench for cool_heat_fan_ctrl. Edge n (counted from reset release) sees cnt=(n-1)%256.
module tb_cool_heat_fan_ctrl;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] temperature = 8'd0;
    logic       temp_valid = 1'b0;
    logic [7:0] cnt = 8'd0;
    logic       heater_on, cooler_on, fan_pwm;
    logic [1:0] fan_level;

    int compared = 0;
    int mismatched = 0;
    int n = 0;
    int highs;

    always #5 clk = ~clk;

    cool_heat_fan_ctrl dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .cnt         (cnt),
        .heater_on   (heater_on),
        .cooler_on   (cooler_on),
        .fan_pwm     (fan_pwm),
        .fan_level   (fan_level)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        cnt = cnt + 8'd1;
        chk("never_both_on", int'(heater_on & cooler_on), 0);
    endtask

    task automatic goto_edge(input int k);
        while (n < k) tick();
    endtask

    // Apply a sampled temperature on edge k.
    task automatic apply_temp(input int k, input logic [7:0] t);
        goto_edge(k - 1);
        temperature = t;
        temp_valid  = 1'b1;
        tick();
        temp_valid  = 1'b0;
    endtask

    // Count fan_pwm highs observed after edges first..last.
    task automatic count_pwm(input int first, input int last, output int cnt_hi);
        cnt_hi = 0;
        goto_edge(first - 1);
        while (n < last) begin
            tick();
            if (fan_pwm) cnt_hi++;
        end
    endtask

    initial begin
        #12;
        chk("reset_heater", int'(heater_on), 0);
        chk("reset_cooler", int'(cooler_on), 0);
        chk("reset_pwm", int'(fan_pwm), 0);
        chk("reset_level", int'(fan_level), 0);
        #1 arst_n = 1'b1;

        // Heat cycle
        apply_temp(1, 8'd10);
        goto_edge(65); chk("heat_not_before_dwell", int'(heater_on), 0);
        goto_edge(66); chk("heat_on", int'(heater_on), 1);
        chk("heat_cooler_off", int'(cooler_on), 0);
        chk("heat_level_before_wrap", int'(fan_level), 0);
        goto_edge(255); chk("heat_level_last_old", int'(fan_level), 0);
        goto_edge(256); chk("heat_level_wrap", int'(fan_level), 1);
        count_pwm(257, 512, highs); chk("heat_duty100", highs, 100);
        apply_temp(513, 8'd29);
        goto_edge(530); chk("heat_hold_29", int'(heater_on), 1);
        apply_temp(531, 8'd30);
        goto_edge(532); chk("heat_exit_lag", int'(heater_on), 1);
        goto_edge(533); chk("heat_exit", int'(heater_on), 0);
        goto_edge(767); chk("idle_level_hold", int'(fan_level), 1);
        goto_edge(768); chk("idle_level_wrap", int'(fan_level), 0);
        goto_edge(770); chk("idle_pwm_off", int'(fan_pwm), 0);

        // Cool bands
        apply_temp(800, 8'd38);
        goto_edge(801); chk("cool_lag", int'(cooler_on), 0);
        goto_edge(802); chk("cool_on", int'(cooler_on), 1);
        chk("cool_heater_off", int'(heater_on), 0);
        goto_edge(1024); chk("cool_level_low", int'(fan_level), 1);
        count_pwm(1025, 1280, highs); chk("cool_duty100", highs, 100);
        // Band change mid-period (cnt=50) must not disturb the current period
        count_pwm(1281, 1330, highs);
        apply_temp(1331, 8'd42);
        if (fan_pwm) highs++;
        begin
            int rest;
            count_pwm(1332, 1536, rest);
            chk("glitch_free_period", highs + rest, 100);
        end
        chk("mid_level_wrap", int'(fan_level), 2);
        goto_edge(1537); chk("mid_pwm_start", int'(fan_pwm), 1);
        count_pwm(1538, 1792, highs); chk("mid_duty180", highs + 1, 180);
        apply_temp(1800, 8'd50);
        goto_edge(2048); chk("high_level", int'(fan_level), 3);
        count_pwm(2049, 2304, highs); chk("high_duty255", highs, 255);
        chk("high_low_at_255", int'(fan_pwm), 0);
        apply_temp(2310, 8'd24);
        goto_edge(2311); chk("cool_exit_lag", int'(cooler_on), 1);
        goto_edge(2312); chk("cool_exit", int'(cooler_on), 0);

        // Hysteresis edges
        apply_temp(2600, 8'd15);
        goto_edge(2700); chk("edge15_no_heat", int'(heater_on), 0);
        apply_temp(2701, 8'd35);
        goto_edge(2800); chk("edge35_no_cool", int'(cooler_on), 0);
        apply_temp(2801, 8'd36);
        goto_edge(2802); chk("edge36_lag", int'(cooler_on), 0);
        goto_edge(2803); chk("edge36_cool", int'(cooler_on), 1);
        apply_temp(2900, 8'd25);
        goto_edge(2950); chk("edge25_stay_cool", int'(cooler_on), 1);

        // Dwell, no direct COOL->HEAT
        apply_temp(2960, 8'd20);
        goto_edge(2962); chk("back_to_idle", int'(cooler_on), 0);
        apply_temp(3040, 8'd40);
        goto_edge(3042); chk("recool", int'(cooler_on), 1);
        apply_temp(3045, 8'd5);
        goto_edge(3106); chk("dwell_cool_hold", int'(cooler_on), 1);
        goto_edge(3107); chk("dwell_cool_exit", int'(cooler_on), 0);
        chk("no_direct_heat", int'(heater_on), 0);
        goto_edge(3171); chk("idle_dwell_hold", int'(heater_on), 0);
        goto_edge(3172); chk("heat_after_idle", int'(heater_on), 1);

        // Async reset mid-period while in COOL
        apply_temp(3250, 8'd50);
        goto_edge(3317); chk("pre_rst_cool", int'(cooler_on), 1);
        goto_edge(3400);
        chk("pre_rst_level", int'(fan_level), 3);
        chk("pre_rst_pwm", int'(fan_pwm), 1);
        #2 arst_n = 1'b0;
        #1;
        chk("async_rst_cooler", int'(cooler_on), 0);
        chk("async_rst_heater", int'(heater_on), 0);
        chk("async_rst_pwm", int'(fan_pwm), 0);
        chk("async_rst_level", int'(fan_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
